// File: rtl/calc_pkg.sv
// calc_pkg: shared types, width and helpers for the calculator arithmetic paths.
package calc_pkg;
    localparam int CALC_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} div_state_t;
    function automatic logic [CALC_WIDTH-1:0] twos_neg(input logic [CALC_WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done request bus between control unit and divider.
interface seq_divider_if #(parameter int WIDTH = calc_pkg::CALC_WIDTH);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (output start, signed_op, dividend, divisor,
                    input busy, done, quotient, remainder, div_by_zero);
    modport slave (input start, signed_op, dividend, divisor,
                   output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in a dividend bit, trial subtract).
module div_step import calc_pkg::*; #(parameter int WIDTH = CALC_WIDTH) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] t;
    always_comb begin
        sh       = {rem, q_in};
        t        = sh - {1'b0, dvs};
        q_bit    = ~t[WIDTH];
        rem_next = q_bit ? t[WIDTH-1:0] : sh[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per clock, signed or unsigned.
module seq_divider import calc_pkg::*; #(parameter int WIDTH = CALC_WIDTH) (
    input logic        clk,
    input logic        reset,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    div_state_t       state, next;
    logic [WIDTH-1:0] rem, quo, dvs, rem_next;
    logic [WIDTH-1:0] quotient, remainder;
    logic [CW-1:0]    count;
    logic             neg_q, neg_r, q_bit, done, div_by_zero, busy;
    logic             accept;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem), .q_in(quo[WIDTH-1]), .dvs(dvs), .rem_next(rem_next), .q_bit(q_bit)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next;
    always_comb begin
        accept = state == IDLE && bus.start;
        next = state == IDLE   ? (bus.start ? (bus.divisor == '0 ? DONE : DIVIDE) : IDLE) :
               state == DIVIDE ? (count == '0 ? FIXUP : DIVIDE) :
               state == FIXUP  ? DONE : IDLE;
    end
    always_comb busy = state == DIVIDE || state == FIXUP;
    // Magnitudes are taken only for signed requests; the most negative value maps to 2^(WIDTH-1).
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= state == DONE;
            if (accept) begin
                neg_q <= bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                neg_r <= bus.signed_op & bus.dividend[WIDTH-1];
                quo   <= bus.signed_op && bus.dividend[WIDTH-1] ? twos_neg(bus.dividend) : bus.dividend;
                dvs   <= bus.signed_op && bus.divisor[WIDTH-1] ? twos_neg(bus.divisor) : bus.divisor;
                rem   <= '0;
                count <= CW'(WIDTH - 1);
                if (bus.divisor == '0) begin
                    quotient    <= '1;
                    remainder   <= bus.dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == DIVIDE) begin
                rem   <= rem_next;
                quo   <= {quo[WIDTH-2:0], q_bit};
                count <= count - 1'b1;
            end else if (state == FIXUP) begin
                quotient    <= neg_q ? twos_neg(quo) : quo;
                remainder   <= neg_r ? twos_neg(rem) : rem;
                div_by_zero <= 1'b0;
            end
        end
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed scoreboard bench for seq_divider (latency, signs, div-by-zero, abort).
module tb_seq_divider;
    import calc_pkg::*;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
        int          busy;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   nchk = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   t0 = 0;
    seq_divider_if bus();
    seq_divider dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic issue(input logic sop, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic z,
                         input int lat, input int bsy, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_op = sop;
        bus.dividend = a;
        bus.divisor = b;
        if (push) sb.push_back('{q, r, z, lat, bsy});
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
    endtask
    task automatic wait_done(input string tag, input bit noise);
        int n = 0;
        int busy_n = 0;
        exp_t e;
        while (!bus.done && n < 60) begin
            if (bus.busy) busy_n++;
            if (noise && (n == 5 || n == 20)) begin
                bus.start = 1'b1;
                bus.signed_op = 1'b1;
                bus.dividend = $urandom;
                bus.divisor = $urandom | 32'd1;
            end else bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_quotient"}, bus.quotient, e.q);
            check({tag, "_remainder"}, bus.remainder, e.r);
            check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.z});
            check({tag, "_latency"}, cyc - t0, e.lat);
            check({tag, "_busy_cycles"}, busy_n, e.busy);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask
    task automatic quiet(input string tag, input int n);
        int done_n = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        check(tag, done_n, 0);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        reset = 1'b0;
        issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 34, 33, 1);
        wait_done("u_100_7", 0);
        issue(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 34, 33, 1);
        wait_done("s_m7_2", 0);
        issue(1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0, 34, 33, 1);
        wait_done("s_7_m2", 0);
        issue(0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 0, 34, 33, 1);
        wait_done("u_big_2", 0);
        issue(0, 32'd25, 32'd0, 32'hFFFFFFFF, 32'd25, 1, 1, 0, 1);
        wait_done("u_div0", 0);
        issue(1, 32'd25, 32'd0, 32'hFFFFFFFF, 32'd25, 1, 1, 0, 1);
        wait_done("s_div0", 0);
        issue(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 34, 33, 1);
        wait_done("s_ovf", 0);
        issue(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 34, 33, 1);
        wait_done("u_max_1", 0);
        issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 34, 33, 1);
        wait_done("noise", 1);
        quiet("noise_single_done", 40);
        issue(0, 32'd100, 32'd7, 32'd0, 32'd0, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        check("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        quiet("abort_no_done", 40);
        issue(0, 32'd1000, 32'd10, 32'd100, 32'd0, 0, 34, 33, 1);
        wait_done("u_1000_10", 0);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential radix-2 restoring divider for the 32-bit arithmetic calculator; it is the inverse companion of the Booth shift multiplier.
- Produces one quotient bit per clock. Signed and unsigned operation is selectable per request.
- Uses a start/busy/done handshake driven by the calculator control unit.
- Outputs are registered and hold their value until the next operation completes.

Parameters:
- WIDTH, 32, operand/result width in bits (the counter is sized $clog2(WIDTH)).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; results valid in the same cycle
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  set with done when divisor==0; held with results

Behaviour:
- Decided interface: reset reset, asynchronous, active-high; clock clk.
- Reset (any time, including mid-operation):
  - state=IDLE
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0
  - internal rem/quo/count cleared
  - an aborted operation produces no done
- States: IDLE, DIVIDE, FIXUP, DONE.
- IDLE, start=1 at edge E0:
  - latch neg_q = signed_op & (dividend[MSB]^divisor[MSB]) and neg_r = signed_op & dividend[MSB].
  - latch |dividend| and |divisor| (magnitudes only when signed_op; the magnitude of the most negative value is 2^(WIDTH-1) as unsigned).
  - rem=0, count=WIDTH-1.
  - if divisor==0, go to DONE with quotient=all ones, remainder=dividend (raw input), div_by_zero=1; done is visible after E0+1.
  - otherwise go to DIVIDE.
- DIVIDE, one iteration per edge:
  - sh = {rem[WIDTH-1:0], quo[MSB]}, WIDTH+1 bits
  - t = sh - {0,dvs}
  - if t[WIDTH]==0: rem=t, quo={quo<<1,1}; else rem=sh, quo={quo<<1,0}
  - count decrements; after WIDTH iterations (edges E0+1..E0+WIDTH) go to FIXUP.
- FIXUP (edge E0+WIDTH+1):
  - quotient = neg_q ? -quo : quo
  - remainder = neg_r ? -rem : rem
  - div_by_zero=0
  - go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; the next edge returns to IDLE. Total latency is start edge to done-high = WIDTH+2 edges (34 for WIDTH=32).
- busy=1 in DIVIDE and FIXUP only.
- start while not IDLE is ignored (no queueing); operand changes while busy have no effect.
- start high in the DONE cycle is ignored; it is accepted in the following IDLE cycle.
- Signed overflow, most-negative / -1 (0x80000000/0xFFFFFFFF): quotient=0x80000000, remainder=0, div_by_zero=0. This falls out naturally; no special case is needed.
- Remainder sign follows the dividend and |remainder| < |divisor| (truncating division).
- quotient, remainder and div_by_zero change only on entry to DONE.

Decomposition:
- Shared package calc_pkg holds:
  - div_state_t enum {IDLE, DIVIDE, FIXUP, DONE}
  - CALC_WIDTH=32 localparam
  - a twos_neg function shared with the multiplier path.
- One combinational sub-module, div_step: inputs rem, next quotient bit, divisor; outputs the next rem and the quotient bit. This keeps the iteration testable in isolation.
- FSM, counter and sign fixup live in seq_divider.

Test Plan:
- Unsigned 100/7, signed_op=0 -> done exactly 34 cycles after the start edge; quotient=14, remainder=2, div_by_zero=0; busy high for 33 cycles.
- Signed -7/2 (0xFFFFFFF9/2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7/-2 -> quotient=-3, remainder=1. Unsigned 0xFFFFFFF9/2 -> quotient=0x7FFFFFFC, remainder=1.
- Divide by zero, 25/0 (both modes) -> done on the 2nd edge after start; quotient=0xFFFFFFFF, remainder=25, div_by_zero=1; busy never asserts.
- Overflow, signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- start pulsed with different operands at cycles 5 and 20 of an in-flight 100/7 -> ignored; the result is still 14 r 2 and exactly one done pulse.
- reset asserted asynchronously at cycle 10 of an operation -> busy=0 and all outputs 0 immediately, no done. A fresh 1000/10 afterwards -> quotient=100, remainder=0 after 34 cycles.
